// File: rtl/clock_reset_seq.sv
// ============================================================================
// Module   : clock_reset_seq
// Brief    : Staggered per-channel reset release behind synchronised lock and
//            external reset, plus programmable divided clocks and enables.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_reset_seq #(
  parameter int NCH       = 3,
  parameter int DIV_W     = 8,
  parameter int DEBOUNCE  = 4,
  parameter int STAGE_DLY = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ext_reset_n,
  input  logic                 pll_lock,
  input  logic [NCH*DIV_W-1:0] div_cfg,
  input  logic                 div_load,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       clk_en_out,
  output logic [NCH-1:0]       rst_n_out,
  output logic                 all_ready,
  output logic                 pll_lock_n
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int SW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DW-1:0] c_deb_max  = DW'(DEBOUNCE);
  localparam logic [SW-1:0] c_stg_last = SW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] c_idx_last = IW'(NCH - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    WAIT_OK = 2'd1,
    STAGE   = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic [1:0]     r_ext_sync;
  logic [1:0]     r_lock_sync;
  logic           r_lock_n;
  logic           w_ok;
  logic [DW-1:0]  r_deb;
  logic [DW-1:0]  w_deb_next;
  logic           w_done_next;
  state_t         r_state;
  state_t         w_state_next;
  logic [SW-1:0]  r_stg;
  logic [SW-1:0]  w_stg_next;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_idx_next;
  logic [NCH-1:0] r_rst_n;
  logic [NCH-1:0] w_rst_n_next;
  logic           r_ready;
  logic           w_ready_next;
  logic           w_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_sync  <= 2'b00;
      r_lock_sync <= 2'b00;
      r_lock_n    <= 1'b1;
      r_deb       <= '0;
    end else begin
      r_ext_sync  <= {r_ext_sync[0], ext_reset_n};
      r_lock_sync <= {r_lock_sync[0], pll_lock};
      r_lock_n    <= ~r_lock_sync[1];
      r_deb       <= w_deb_next;
    end
  end

  assign w_ok = r_ext_sync[1] & r_lock_sync[1];

  always_comb begin
    w_deb_next = '0;
    if (w_ok)
      w_deb_next = (r_deb == c_deb_max) ? r_deb : r_deb + DW'(1);
  end

  // Leave WAIT_OK on the edge the count saturates so the first stage cycle
  // overlaps the final debounce cycle.
  assign w_done_next = (w_deb_next == c_deb_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HOLD;
      r_stg   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_stg   <= w_stg_next;
      r_idx   <= w_idx_next;
      r_rst_n <= w_rst_n_next;
      r_ready <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stg_next   = r_stg;
    w_idx_next   = r_idx;
    w_rst_n_next = r_rst_n;
    w_ready_next = r_ready;
    if (r_state == HOLD) begin
      w_state_next = WAIT_OK;
      w_rst_n_next = '0;
      w_ready_next = 1'b0;
    end else if (!w_ok) begin
      w_state_next = WAIT_OK;
      w_stg_next   = '0;
      w_idx_next   = '0;
      w_rst_n_next = '0;
      w_ready_next = 1'b0;
    end else begin
      case (r_state)
        WAIT_OK: begin
          if (w_done_next) begin
            w_state_next = STAGE;
            w_stg_next   = '0;
            w_idx_next   = '0;
          end
        end
        STAGE: begin
          if (r_stg == c_stg_last) begin
            w_stg_next          = '0;
            w_rst_n_next[r_idx] = 1'b1;
            if (r_idx == c_idx_last) begin
              w_state_next = RUN;
              w_ready_next = 1'b1;
            end else begin
              w_idx_next = r_idx + IW'(1);
            end
          end else begin
            w_stg_next = r_stg + SW'(1);
          end
        end
        RUN: begin
          w_rst_n_next = '1;
          w_ready_next = 1'b1;
        end
        default: begin
          w_state_next = WAIT_OK;
        end
      endcase
    end
  end

  assign w_run = (r_state != HOLD);

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_div
      logic [DIV_W-1:0] r_pend;
      logic [DIV_W-1:0] r_cur;
      logic [DIV_W-1:0] r_hc;
      logic             r_clk;
      logic             r_en;
      logic             w_wrap;

      assign w_wrap = (r_hc == r_cur);

      // A new divide value only takes effect at a toggle, so no half-period
      // is ever cut short by a load.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pend <= '0;
          r_cur  <= '0;
          r_hc   <= '0;
          r_clk  <= 1'b0;
          r_en   <= 1'b0;
        end else begin
          if (div_load)
            r_pend <= div_cfg[g*DIV_W +: DIV_W];
          if (!w_run) begin
            r_hc  <= '0;
            r_clk <= 1'b0;
            r_en  <= 1'b0;
          end else if (w_wrap) begin
            r_hc  <= '0;
            r_clk <= ~r_clk;
            r_en  <= ~r_clk;
            r_cur <= div_load ? div_cfg[g*DIV_W +: DIV_W] : r_pend;
          end else begin
            r_hc <= r_hc + DIV_W'(1);
            r_en <= 1'b0;
          end
        end
      end

      assign clk_out[g]    = r_clk;
      assign clk_en_out[g] = r_en;
    end
  endgenerate

  assign rst_n_out  = r_rst_n;
  assign all_ready  = r_ready;
  assign pll_lock_n = r_lock_n;

endmodule

`default_nettype wire

// File: tb/tb_clock_reset_seq.sv
// ============================================================================
// Module   : tb_clock_reset_seq
// Brief    : Self-checking bench for clock_reset_seq (stagger, abort, divider).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clock_reset_seq;

  localparam int NCH = 3;
  localparam int DIV_W = 8;
  localparam int DEB = 4;
  localparam int STG = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             ext_reset_n;
  logic             pll_lock;
  logic [NCH*DIV_W-1:0] div_cfg;
  logic             div_load;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   clk_en_out;
  logic [NCH-1:0]   rst_n_out;
  logic             all_ready;
  logic             pll_lock_n;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] cfg;
    int          half0;
    int          half1;
    int          half2;
  } dvec_t;

  typedef struct {
    int ch;
    int half;
  } exp_t;

  dvec_t vecs [2];
  exp_t  sb [$];
  exp_t  e;
  int    hi, lo, hi2, eb;
  bit    to;

  clock_reset_seq #(
    .NCH(NCH), .DIV_W(DIV_W), .DEBOUNCE(DEB), .STAGE_DLY(STG)
  ) dut (
    .clk(clk), .reset(reset), .ext_reset_n(ext_reset_n), .pll_lock(pll_lock),
    .div_cfg(div_cfg), .div_load(div_load), .clk_out(clk_out),
    .clk_en_out(clk_en_out), .rst_n_out(rst_n_out), .all_ready(all_ready),
    .pll_lock_n(pll_lock_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edge e counts from the first edge after reset release or after the final
  // rise of the asynchronous inputs.
  task automatic stagger(input string tag, input int n, input bit from_reset);
    logic [NCH-1:0] exp_rst;
    for (int ed = 1; ed <= n; ed++) begin
      tick();
      for (int i = 0; i < NCH; i++)
        exp_rst[i] = (ed >= 2 + DEB + (i + 1) * STG);
      chk($sformatf("%s rst_n e%0d", tag, ed), rst_n_out, exp_rst);
      chk($sformatf("%s ready e%0d", tag, ed), all_ready, ed >= 2 + DEB + NCH * STG);
      chk($sformatf("%s lock_n e%0d", tag, ed), pll_lock_n, ed < 3);
      if (from_reset && ed == 1) chk($sformatf("%s clk_out e1", tag), clk_out, 3'b000);
      if (from_reset && ed == 2) begin
        chk($sformatf("%s clk_out e2", tag), clk_out, 3'b111);
        chk($sformatf("%s clk_en e2", tag), clk_en_out, 3'b111);
      end
    end
  endtask

  task automatic wait_rise(input int ch, output bit timeout);
    logic prev;
    prev = clk_out[ch];
    timeout = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!prev && clk_out[ch]) begin
        timeout = 1'b0;
        break;
      end
      prev = clk_out[ch];
    end
  endtask

  task automatic measure(input int ch, output int h, output int l, output int bad, output bit timeout);
    h = 0; l = 0; bad = 0;
    wait_rise(ch, timeout);
    if (!clk_en_out[ch]) bad++;
    while (clk_out[ch] && h < 100) begin
      h++;
      if (h > 1 && clk_en_out[ch]) bad++;
      tick();
    end
    while (!clk_out[ch] && l < 100) begin
      l++;
      if (clk_en_out[ch]) bad++;
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{cfg: 24'h00_01_03, half0: 4, half1: 2, half2: 1};
    vecs[1] = '{cfg: 24'h09_02_00, half0: 1, half1: 3, half2: 10};

    reset = 1'b1; ext_reset_n = 1'b1; pll_lock = 1'b1; div_cfg = '0; div_load = 1'b0;
    repeat (5) tick();
    chk("reset clk_out", clk_out, 3'b000);
    chk("reset clk_en", clk_en_out, 3'b000);
    chk("reset rst_n", rst_n_out, 3'b000);
    chk("reset ready", all_ready, 1'b0);
    chk("reset lock_n", pll_lock_n, 1'b1);

    reset = 1'b0;
    stagger("boot", 60, 1'b1);

    // Divider table: expected half-periods queued when the config is driven.
    for (int v = 0; v < 2; v++) begin
      div_cfg = vecs[v].cfg;
      div_load = 1'b1;
      sb.push_back('{ch: 0, half: vecs[v].half0});
      sb.push_back('{ch: 1, half: vecs[v].half1});
      sb.push_back('{ch: 2, half: vecs[v].half2});
      tick();
      div_load = 1'b0;
      repeat (30) tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        measure(e.ch, hi, lo, eb, to);
        chk($sformatf("div v%0d ch%0d timeout", v, e.ch), to, 1'b0);
        chk($sformatf("div v%0d ch%0d high", v, e.ch), hi, e.half);
        chk($sformatf("div v%0d ch%0d low", v, e.ch), lo, e.half);
        chk($sformatf("div v%0d ch%0d en", v, e.ch), eb, 0);
      end
    end

    // ch1 2 -> 0 loaded one cycle into a high half-period.
    wait_rise(1, to);
    chk("reload sync", to, 1'b0);
    div_cfg = 24'h09_00_00; div_load = 1'b1; hi = 1;
    tick();
    div_load = 1'b0;
    while (clk_out[1] && hi < 50) begin hi++; tick(); end
    lo = 0;
    while (!clk_out[1] && lo < 50) begin lo++; tick(); end
    hi2 = 0;
    while (clk_out[1] && hi2 < 50) begin hi2++; tick(); end
    chk("reload hi old", hi, 3);
    chk("reload lo new", lo, 1);
    chk("reload hi new", hi2, 1);

    // ch2 9 -> 1 loaded exactly on the toggling edge.
    wait_rise(2, to);
    chk("coinc sync", to, 1'b0);
    repeat (9) tick();
    chk("coinc still high", clk_out[2], 1'b1);
    div_cfg = 24'h01_00_00; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    chk("coinc toggled", clk_out[2], 1'b0);
    lo = 0;
    while (!clk_out[2] && lo < 50) begin lo++; tick(); end
    hi = 0;
    while (clk_out[2] && hi < 50) begin hi++; tick(); end
    chk("coinc lo new", lo, 2);
    chk("coinc hi new", hi, 2);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    tick();
    chk("loss e1 rst_n", rst_n_out, 3'b111);
    tick();
    chk("loss e2 rst_n", rst_n_out, 3'b111);
    chk("loss e2 lock_n", pll_lock_n, 1'b0);
    tick();
    chk("loss e3 rst_n", rst_n_out, 3'b000);
    chk("loss e3 ready", all_ready, 1'b0);
    chk("loss e3 lock_n", pll_lock_n, 1'b1);
    repeat (5) tick();

    // Glitchy relock then full stagger from the final rise.
    pll_lock = 1'b1;
    repeat (3) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    pll_lock = 1'b1;
    stagger("relock", 60, 1'b0);

    // Reset asserted after channel 0 has been released.
    pll_lock = 1'b0;
    repeat (5) tick();
    pll_lock = 1'b1;
    stagger("prerst", 25, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst clk_out", clk_out, 3'b000);
    chk("midrst clk_en", clk_en_out, 3'b000);
    chk("midrst rst_n", rst_n_out, 3'b000);
    chk("midrst ready", all_ready, 1'b0);
    chk("midrst lock_n", pll_lock_n, 1'b1);
    reset = 1'b0;
    stagger("rerun", 60, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_reset_seq.md
Name: clock_reset_seq

Overview:
Parametrised reset sequencer and clock-enable generator for NCH downstream domains, all derived from one system clock. Synchronises and debounces the external reset pin and the PLL lock indication, then releases the per-channel resets one after another with a fixed stagger. Also generates a programmable divided clock and a rising-edge enable pulse per channel. Lock loss or an external reset during operation collapses every channel back into reset. Sits directly behind the PLL at the top of the chip clocking tree.

Parameters:
NCH, 3, number of downstream channels (1..8)
DIV_W, 8, width of each per-channel divide value
DEBOUNCE, 4, consecutive cycles of "ok" (ext reset released AND lock high) required before sequencing starts (>=1)
STAGE_DLY, 16, cycles between consecutive channel releases, and from debounce-complete to channel 0 release (>=1)

Ports:
clk  in  1  system clock; the only clock in the block
reset  in  1  synchronous, active-high reset
ext_reset_n  in  1  asynchronous external reset pin, active low
pll_lock  in  1  asynchronous PLL lock indication
div_cfg  in  NCH*DIV_W  per-channel divide values; channel i occupies bits [i*DIV_W +: DIV_W]
div_load  in  1  one-cycle strobe that captures div_cfg into the shadow registers
clk_out  out  NCH  divided clock per channel
clk_en_out  out  NCH  one-cycle pulse per channel, high in the cycle its clk_out goes 0->1
rst_n_out  out  NCH  per-channel reset, active low
all_ready  out  1  high when every channel is out of reset
pll_lock_n  out  1  inverted, synchronised lock status

Behaviour:
- Reset values (reset=1): clk_out=0, clk_en_out=0, rst_n_out=0, all_ready=0, pll_lock_n=1, state=HOLD.
- Shadow divide registers reset to 0, i.e. clk/2 on every channel.
- Input synchronisation: ext_reset_n and pll_lock each pass through a 2-flop synchroniser. ok = ext_sync & lock_sync.
- pll_lock_n = ~lock_sync, registered.
- Debounce counter:
  - Cleared whenever ok=0.
  - Increments while ok=1, saturating at DEBOUNCE.
  - done = (count == DEBOUNCE).
- State machine (encoded states HOLD, WAIT_OK, STAGE, RUN):
  - HOLD: entered only via reset; dividers stopped. Leaves for WAIT_OK on the first cycle with reset=0.
  - WAIT_OK: dividers running, all rst_n_out=0. When done=1: clear the stage counter, set idx=0, go to STAGE.
  - STAGE: stage counter counts up to STAGE_DLY-1. At terminal count: rst_n_out[idx] goes 1 on the next edge and the counter clears. If idx==NCH-1, go to RUN; otherwise idx increments.
  - RUN: all rst_n_out=1 and all_ready=1. all_ready rises on the same edge as rst_n_out[NCH-1].
- Abort: ok=0 in WAIT_OK, STAGE or RUN means that on the next edge all rst_n_out=0, all_ready=0, the debounce counter clears and state goes to WAIT_OK. Dividers keep running.
- Release timing with ext_reset_n=1 and pll_lock=1 steady: rst_n_out[i] rises exactly 2+DEBOUNCE+(i+1)*STAGE_DLY edges after the first edge with reset=0.
- Abort timing: rst_n_out drops on the 3rd edge after either asynchronous input falls, including mid-STAGE.
- Divider (per channel, value D):
  - Half-period counter runs 0..D; clk_out toggles when it wraps.
  - Output period is 2*(D+1) cycles at 50% duty. D=0 gives clk/2.
- div_load captures div_cfg into pending registers. Each channel adopts its pending value only at its next toggle, so a load never produces a half-period shorter than min(old D, new D)+1.
  - div_load coincident with a toggle: the toggle completes using the old D, and the new D governs the following half-period.
- clk_out and clk_en_out stay 0 in HOLD. Counters start at 0 when WAIT_OK is entered.
- Reset asserted mid-operation: the next edge restores all reset values, with no sequencing.

Test Plan:
- Release sequence: reset 5 cycles then 0, ext_reset_n=1 and pll_lock=1 steady, defaults -> rst_n_out[0] rises at edge 22, [1] at edge 38, [2] at edge 54; all_ready at edge 54.
- Debounce glitch: pll_lock rises, drops for 2 cycles after 3 cycles, then stays high -> no rst_n_out release until DEBOUNCE+STAGE_DLY+2 edges after the final rise.
- Lock loss in RUN: pll_lock 1->0 -> all rst_n_out=0, all_ready=0 and pll_lock_n=1 by the 3rd edge; relock re-runs the full stagger.
- Divider: div_cfg ch0=0, ch1=2, ch2=9 -> periods 2, 6 and 20 cycles at 50% duty; clk_en_out is a single-cycle pulse aligned to each rising edge.
- Divider reload: ch1 D=2 -> 0 with div_load mid-half-period -> current half-period completes at 3 cycles, then period 2; no pulse shorter than 1 cycle.
- Reset mid-STAGE: reset=1 after channel 0 is released -> every output at its reset value on the next edge; state HOLD.
